// File: rtl/rr_grant_scheduler_8_pkg.sv
// Shared types and constants for the 8-way round-robin grant scheduler.
`timescale 1ns/1ps
package rr_grant_scheduler_8_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_grant_scheduler_8_pick.sv
// Combinational round-robin winner search: rotate so ptr+1 is bit 0,
// take the lowest set bit, then rotate the index back.
`timescale 1ns/1ps
module rr_pick_8
    import rr_grant_scheduler_8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               found_o,
    output logic [ID_W-1:0]    winner_o
);

    logic [ID_W-1:0]      start;
    logic [ID_W-1:0]      idx;
    logic [2*NUM_REQ-2:0] dbl;
    logic [NUM_REQ-1:0]   rot;

    assign start = ptr_i + ID_W'(1);
    assign dbl   = {req_i[NUM_REQ-2:0], req_i};
    assign rot   = dbl[start +: NUM_REQ];

    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign found_o  = |req_i;
    assign winner_o = idx + start;

endmodule

// File: rtl/rr_grant_scheduler_8.sv
// Round-robin arbiter for one 8-way resource: registered one-hot grant held
// until release or hold limit, followed by a fixed all-zero turnaround gap.
`timescale 1ns/1ps
module rr_grant_scheduler_8
    import rr_grant_scheduler_8_pkg::*;
#(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_valid,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [2:0]       GAP_LAST  = 3'(GAP_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         gap_q, gap_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;

    logic               found;
    logic [ID_W-1:0]    winner;
    logic               hold_expired;

    rr_pick_8 u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .found_o  (found),
        .winner_o (winner)
    );

    assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

    // Next-state and next-output logic; release beats timeout on a tie.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        grant_d   = grant_q;
        id_d      = id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    grant_d = ONE << winner;
                    id_d    = winner;
                    valid_d = 1'b1;
                    ptr_d   = winner;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!req[id_q] || !enable) begin
                    grant_d = '0;
                    valid_d = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (hold_expired) begin
                    grant_d   = '0;
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    gap_d     = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 3'd1;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            gap_q     <= '0;
            grant_q   <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = id_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule
